// File: rtl/parallel16_matrix_multiplier_pkg.sv
// Shared constants for the 4x4 parallel matrix multiplier.
//   DATA_W_DEF : default unsigned operand element width
//   RES_W_DEF  : default unsigned result element width (>= 2*DATA_W+2)
//   N          : matrix dimension
package parallel16_matrix_multiplier_pkg;
   localparam int DATA_W_DEF = 3;
   localparam int RES_W_DEF  = 8;
   localparam int N          = 4;
endpackage

// File: rtl/parallel16_matrix_multiplier_dot4.sv
// Combinational 4-term unsigned dot product: sum = a0*b0 + a1*b1 + a2*b2 + a3*b3.
//   a0..a3, b0..b3 : DATA_W operand pairs
//   sum            : RES_W full-precision result
module parallel16_matrix_multiplier_dot4
   import parallel16_matrix_multiplier_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RES_W  = RES_W_DEF
) (
   input  logic [DATA_W-1:0] a0,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] a2,
   input  logic [DATA_W-1:0] a3,
   input  logic [DATA_W-1:0] b0,
   input  logic [DATA_W-1:0] b1,
   input  logic [DATA_W-1:0] b2,
   input  logic [DATA_W-1:0] b3,
   output logic [RES_W-1:0]  sum
);

   // Operands are widened before multiplying so every product and the
   // running sum are carried at full result width.
   logic [RES_W-1:0] p0, p1, p2, p3;

   always_comb begin
      p0  = RES_W'(a0) * RES_W'(b0);
      p1  = RES_W'(a1) * RES_W'(b1);
      p2  = RES_W'(a2) * RES_W'(b2);
      p3  = RES_W'(a3) * RES_W'(b3);
      sum = (p0 + p1) + (p2 + p3);
   end

endmodule

// File: rtl/parallel16_matrix_multiplier.sv
// 4x4 unsigned matrix multiplier, one product per cycle, one cycle latency.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid            : qualifies a00..a33 / b00..b33 this cycle
//   a00..a33, b00..b33  : operand matrices (aRC = row R, column C)
//   out_valid           : res00..res33 carry a new product this cycle
//   res00..res33        : registered product matrix
module parallel16_matrix_multiplier
   import parallel16_matrix_multiplier_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RES_W  = RES_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] a00, a01, a02, a03,
   input  logic [DATA_W-1:0] a10, a11, a12, a13,
   input  logic [DATA_W-1:0] a20, a21, a22, a23,
   input  logic [DATA_W-1:0] a30, a31, a32, a33,
   input  logic [DATA_W-1:0] b00, b01, b02, b03,
   input  logic [DATA_W-1:0] b10, b11, b12, b13,
   input  logic [DATA_W-1:0] b20, b21, b22, b23,
   input  logic [DATA_W-1:0] b30, b31, b32, b33,
   output logic              out_valid,
   output logic [RES_W-1:0]  res00, res01, res02, res03,
   output logic [RES_W-1:0]  res10, res11, res12, res13,
   output logic [RES_W-1:0]  res20, res21, res22, res23,
   output logic [RES_W-1:0]  res30, res31, res32, res33
);

   logic [DATA_W-1:0] a_m   [N][N];
   logic [DATA_W-1:0] b_m   [N][N];
   logic [RES_W-1:0]  dot_m [N][N];
   logic [RES_W-1:0]  res_q [N][N];

   assign a_m[0] = '{a00, a01, a02, a03};
   assign a_m[1] = '{a10, a11, a12, a13};
   assign a_m[2] = '{a20, a21, a22, a23};
   assign a_m[3] = '{a30, a31, a32, a33};
   assign b_m[0] = '{b00, b01, b02, b03};
   assign b_m[1] = '{b10, b11, b12, b13};
   assign b_m[2] = '{b20, b21, b22, b23};
   assign b_m[3] = '{b30, b31, b32, b33};

   // Result element (r,c) pairs row r of A with column c of B.
   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         parallel16_matrix_multiplier_dot4 #(
            .DATA_W (DATA_W),
            .RES_W  (RES_W)
         ) u_dot4 (
            .a0  (a_m[r][0]),
            .a1  (a_m[r][1]),
            .a2  (a_m[r][2]),
            .a3  (a_m[r][3]),
            .b0  (b_m[0][c]),
            .b1  (b_m[1][c]),
            .b2  (b_m[2][c]),
            .b3  (b_m[3][c]),
            .sum (dot_m[r][c])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         res_q     <= '{default: '0};
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            res_q <= dot_m;
         end
      end
   end

   assign res00 = res_q[0][0];
   assign res01 = res_q[0][1];
   assign res02 = res_q[0][2];
   assign res03 = res_q[0][3];
   assign res10 = res_q[1][0];
   assign res11 = res_q[1][1];
   assign res12 = res_q[1][2];
   assign res13 = res_q[1][3];
   assign res20 = res_q[2][0];
   assign res21 = res_q[2][1];
   assign res22 = res_q[2][2];
   assign res23 = res_q[2][3];
   assign res30 = res_q[3][0];
   assign res31 = res_q[3][1];
   assign res32 = res_q[3][2];
   assign res33 = res_q[3][3];

endmodule

// File: tb/tb_parallel16_matrix_multiplier.sv
// Self-checking bench for parallel16_matrix_multiplier (DATA_W=3, RES_W=8).
module tb_parallel16_matrix_multiplier;

   typedef struct packed {
      logic [15:0][2:0] a;
      logic [15:0][2:0] b;
      logic [15:0][7:0] res;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [15:0][2:0] a_bus;
   logic [15:0][2:0] b_bus;
   wire              out_valid;
   wire  [15:0][7:0] res_bus;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic             mon_en;
   logic             mon_v;
   logic [15:0][7:0] hold_res;
   logic [15:0][7:0] exp_q[$];
   logic [15:0][7:0] popped;
   vec_t             vecs[4];

   always #5 clk = ~clk;

   parallel16_matrix_multiplier #(.DATA_W(3), .RES_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a00(a_bus[0]),  .a01(a_bus[1]),  .a02(a_bus[2]),  .a03(a_bus[3]),
      .a10(a_bus[4]),  .a11(a_bus[5]),  .a12(a_bus[6]),  .a13(a_bus[7]),
      .a20(a_bus[8]),  .a21(a_bus[9]),  .a22(a_bus[10]), .a23(a_bus[11]),
      .a30(a_bus[12]), .a31(a_bus[13]), .a32(a_bus[14]), .a33(a_bus[15]),
      .b00(b_bus[0]),  .b01(b_bus[1]),  .b02(b_bus[2]),  .b03(b_bus[3]),
      .b10(b_bus[4]),  .b11(b_bus[5]),  .b12(b_bus[6]),  .b13(b_bus[7]),
      .b20(b_bus[8]),  .b21(b_bus[9]),  .b22(b_bus[10]), .b23(b_bus[11]),
      .b30(b_bus[12]), .b31(b_bus[13]), .b32(b_bus[14]), .b33(b_bus[15]),
      .out_valid(out_valid),
      .res00(res_bus[0]),  .res01(res_bus[1]),  .res02(res_bus[2]),  .res03(res_bus[3]),
      .res10(res_bus[4]),  .res11(res_bus[5]),  .res12(res_bus[6]),  .res13(res_bus[7]),
      .res20(res_bus[8]),  .res21(res_bus[9]),  .res22(res_bus[10]), .res23(res_bus[11]),
      .res30(res_bus[12]), .res31(res_bus[13]), .res32(res_bus[14]), .res33(res_bus[15])
   );

   function automatic logic [15:0][2:0] m3(input int v[16]);
      logic [15:0][2:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[i][2:0];
      return r;
   endfunction

   function automatic logic [15:0][7:0] m8(input int v[16]);
      logic [15:0][7:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[i][7:0];
      return r;
   endfunction

   function automatic logic [15:0][2:0] fill3(input int v);
      logic [15:0][2:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[2:0];
      return r;
   endfunction

   function automatic logic [15:0][7:0] fill8(input int v);
      logic [15:0][7:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[7:0];
      return r;
   endfunction

   function automatic logic [15:0][2:0] rand3();
      logic [15:0][2:0] r;
      for (int i = 0; i < 16; i++) r[i] = 3'($urandom_range(7, 0));
      return r;
   endfunction

   // Reference product: plain triple loop over integer arithmetic.
   function automatic logic [15:0][7:0] matmul(input logic [15:0][2:0] a,
                                                input logic [15:0][2:0] b);
      logic [15:0][7:0] r;
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < 4; k++) acc += int'(a[row*4+k]) * int'(b[k*4+col]);
            r[row*4+col] = acc[7:0];
         end
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic [15:0][2:0] a,
                        input logic [15:0][2:0] b, input logic [15:0][7:0] e);
      @(negedge clk);
      in_valid = v;
      a_bus    = a;
      b_bus    = b;
      if (v) exp_q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s out_valid: got %0b required 0", name, out_valid);
      end
      n_checks++;
      if (res_bus !== '0) begin
         n_fail++;
         $display("FAIL %s res: got %h required 0", name, res_bus);
      end
   endtask

   // Scoreboard monitor: every edge, out_valid must equal rst_n&in_valid seen
   // at that edge, and res must equal the newest popped product (or hold).
   always @(posedge clk) begin
      mon_v = rst_n & in_valid;
      #1;
      if (mon_en) begin
         n_checks++;
         if (out_valid !== mon_v) begin
            n_fail++;
            $display("FAIL out_valid @%0t: got %0b required %0b", $time, out_valid, mon_v);
         end
         if (mon_v) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard @%0t: result produced with empty queue", $time);
            end else begin
               popped   = exp_q.pop_front();
               hold_res = popped;
            end
         end
         n_checks++;
         if (res_bus !== hold_res) begin
            n_fail++;
            $display("FAIL res @%0t: got %h required %h", $time, res_bus, hold_res);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0][2:0] sa, sb, ra, rb;

      vecs[0].a   = m3('{5,0,2,0, 1,4,5,1, 1,0,6,3, 5,5,3,7});
      vecs[0].b   = m3('{1,5,6,6, 7,6,6,4, 4,4,0,2, 4,6,3,1});
      vecs[0].res = m8('{13,33,30,34, 53,55,33,33, 37,47,15,21, 80,109,81,63});
      vecs[1].a   = fill3(0); vecs[1].b = fill3(0); vecs[1].res = fill8(0);
      vecs[2].a   = fill3(1); vecs[2].b = fill3(1); vecs[2].res = fill8(4);
      vecs[3].a   = fill3(7); vecs[3].b = fill3(7); vecs[3].res = fill8(196);

      rst_n    = 1'b0;
      in_valid = 1'b0;
      a_bus    = '0;
      b_bus    = '0;
      mon_en   = 1'b0;
      hold_res = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("initial_reset");
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // mixed product, then extremes back-to-back
      for (int i = 0; i < 4; i++) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].res);

      // hold with changing operands
      for (int i = 0; i < 3; i++) drive(1'b0, rand3(), rand3(), '0);

      // sparse product
      sa = m3('{3,5,6,4, 3,6,1,1, 2,4,1,5, 0,7,5,0});
      sb = m3('{7,0,7,6, 3,3,2,6, 5,7,0,7, 0,2,0,1});
      drive(1'b1, sa, sb, matmul(sa, sb));
      @(posedge clk);
      #2;
      n_checks++;
      if (res_bus[0] !== 8'd66) begin
         n_fail++;
         $display("FAIL sparse_res00: got %0d required 66", res_bus[0]);
      end
      n_checks++;
      if (res_bus[15] !== 8'd77) begin
         n_fail++;
         $display("FAIL sparse_res33: got %0d required 77", res_bus[15]);
      end

      // random stream with random gaps
      for (int i = 0; i < 12; i++) begin
         logic v;
         ra = rand3();
         rb = rand3();
         v  = 1'($urandom_range(1, 0)) | (i < 4);
         drive(v, ra, rb, matmul(ra, rb));
      end
      drive(1'b0, '0, '0, '0);

      // async reset with in_valid high and nonzero operands
      drive(1'b1, vecs[3].a, vecs[3].b, vecs[3].res);
      @(posedge clk);
      #3;
      in_valid = 1'b1;
      a_bus    = rand3() | fill3(1);
      b_bus    = fill3(5);
      rst_n    = 1'b0;
      exp_q.delete();
      hold_res = '0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // reset pulse between two valid inputs
      drive(1'b1, vecs[0].a, vecs[0].b, vecs[0].res);
      @(negedge clk);
      in_valid = 1'b1;
      a_bus    = fill3(7);
      b_bus    = fill3(7);
      rst_n    = 1'b0;
      exp_q.delete();
      hold_res = '0;
      #1;
      check_reset_outputs("midstream_reset");
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      ra = rand3();
      rb = rand3();
      drive(1'b1, ra, rb, matmul(ra, rb));
      drive(1'b0, '0, '0, '0);
      @(negedge clk);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
